// File: rtl/conv_mac_12.sv
// Kernel multiply-accumulate for conv layer 12: consumes KERN_S weight/activation
// pairs from two FIFO streams and emits one shifted, saturated result.
module conv_mac_12 #(
   parameter int KERN_S  = 9,
   parameter int COEFF_W = 16,
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 40,
   parameter int SHIFT   = 8
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic [COEFF_W-1:0]  weight_V_dout,
   input  logic                weight_V_empty_n,
   output logic                weight_V_read,
   input  logic [DATA_W-1:0]   input_V_dout,
   input  logic                input_V_empty_n,
   output logic                input_V_read,
   output logic [DATA_W-1:0]   output_V_din,
   input  logic                output_V_full_n,
   output logic                output_V_write
);

   localparam int CNT_W = $clog2(KERN_S + 1);

   localparam logic signed [ACC_W-1:0] MAX_V =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic {ACC, OUT} state_t;

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic        [CNT_W-1:0]  cnt;

   logic signed [ACC_W-1:0]  w_ext;
   logic signed [ACC_W-1:0]  a_ext;
   logic signed [ACC_W-1:0]  prod;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  shifted;
   logic        [DATA_W-1:0] sat_val;
   logic                     fire;
   logic                     last;

   assign w_ext = {{(ACC_W-COEFF_W){weight_V_dout[COEFF_W-1]}}, weight_V_dout};
   assign a_ext = {{(ACC_W-DATA_W){input_V_dout[DATA_W-1]}}, input_V_dout};
   assign prod  = w_ext * a_ext;
   assign sum   = acc + prod;
   assign shifted = sum >>> SHIFT;

   always_comb begin
      sat_val = shifted[DATA_W-1:0];
      if (shifted > MAX_V)
         sat_val = MAX_V[DATA_W-1:0];
      else if (shifted < MIN_V)
         sat_val = MIN_V[DATA_W-1:0];
   end

   // Both strobes come from one term so a lone stream is never popped.
   assign fire = ap_rst_n && (state == ACC)
              && weight_V_empty_n && input_V_empty_n;
   assign last = (cnt == CNT_W'(KERN_S - 1));

   assign weight_V_read  = fire;
   assign input_V_read   = fire;
   assign output_V_write = ap_rst_n && (state == OUT) && output_V_full_n;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state        <= ACC;
         acc          <= '0;
         cnt          <= '0;
         output_V_din <= '0;
      end else begin
         unique case (state)
            ACC: begin
               if (fire) begin
                  acc <= sum;
                  if (last) begin
                     state        <= OUT;
                     output_V_din <= sat_val;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            OUT: begin
               if (output_V_full_n) begin
                  state <= ACC;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule
